// File: rtl/traffic_pkg.sv
//==============================================================================
// Module   : traffic_pkg
// Purpose  : Shared phase encoding, 7-segment codes and error bit indices for
//            the traffic-light controller and its monitor.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package traffic_pkg;

    // Phase encoding doubles as the monitor state encoding (SYNC == none).
    localparam logic [1:0] c_ph_none   = 2'b00;
    localparam logic [1:0] c_ph_red    = 2'b01;
    localparam logic [1:0] c_ph_green  = 2'b10;
    localparam logic [1:0] c_ph_yellow = 2'b11;

    localparam logic [1:0] c_st_sync   = c_ph_none;
    localparam logic [1:0] c_st_red    = c_ph_red;
    localparam logic [1:0] c_st_green  = c_ph_green;
    localparam logic [1:0] c_st_yellow = c_ph_yellow;

    // Segment order {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] c_seg_0 = 7'h3F;
    localparam logic [6:0] c_seg_1 = 7'h06;
    localparam logic [6:0] c_seg_2 = 7'h5B;
    localparam logic [6:0] c_seg_3 = 7'h4F;
    localparam logic [6:0] c_seg_4 = 7'h66;
    localparam logic [6:0] c_seg_5 = 7'h6D;
    localparam logic [6:0] c_seg_6 = 7'h7D;
    localparam logic [6:0] c_seg_7 = 7'h07;
    localparam logic [6:0] c_seg_8 = 7'h7F;
    localparam logic [6:0] c_seg_9 = 7'h6F;

    localparam int c_err_w      = 6;
    localparam int c_err_onehot = 0;
    localparam int c_err_seg    = 1;
    localparam int c_err_step   = 2;
    localparam int c_err_order  = 3;
    localparam int c_err_load   = 4;
    localparam int c_err_early  = 5;

    function automatic logic [1:0] next_phase(input logic [1:0] ph);
        logic [1:0] nxt;
        case (ph)
            c_ph_red:    nxt = c_ph_green;
            c_ph_green:  nxt = c_ph_yellow;
            c_ph_yellow: nxt = c_ph_red;
            default:     nxt = c_ph_none;
        endcase
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
//==============================================================================
// Module   : seg7_decode
// Purpose  : Combinational 7-segment code to BCD digit decoder with legal flag.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module seg7_decode
    import traffic_pkg::*;
(
    input  logic [6:0] i_code,
    output logic [3:0] o_digit,
    output logic       o_legal
);

    always_comb begin
        o_digit = 4'd0;
        o_legal = 1'b1;
        case (i_code)
            c_seg_0: o_digit = 4'd0;
            c_seg_1: o_digit = 4'd1;
            c_seg_2: o_digit = 4'd2;
            c_seg_3: o_digit = 4'd3;
            c_seg_4: o_digit = 4'd4;
            c_seg_5: o_digit = 4'd5;
            c_seg_6: o_digit = 4'd6;
            c_seg_7: o_digit = 4'd7;
            c_seg_8: o_digit = 4'd8;
            c_seg_9: o_digit = 4'd9;
            default: o_legal = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/traffic_light_monitor.sv
//==============================================================================
// Module   : traffic_light_monitor
// Purpose  : Passive checker of traffic-light outputs: decodes the countdown
//            digits, tracks the phase order and flags timing/sequence errors.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter logic [6:0] RED_T    = 7'd30,
    parameter logic [6:0] GREEN_T  = 7'd25,
    parameter logic [6:0] YELLOW_T = 7'd5
)
(
    input  logic        clk_in,
    input  logic        rst,
    input  logic        red,
    input  logic        green,
    input  logic        yellow,
    input  logic [6:0]  seg_tens,
    input  logic [6:0]  seg_ones,
    input  logic        clr_err,
    output logic [6:0]  value,
    output logic        value_valid,
    output logic [1:0]  phase,
    output logic        locked,
    output logic [5:0]  err_flags,
    output logic        err_pulse,
    output logic [15:0] phase_count
);

    // Stage 1: registered inputs and the previous registered vector
    logic [2:0]         r_lights;
    logic [6:0]         r_seg_tens;
    logic [6:0]         r_seg_ones;
    logic               r_clr;
    logic [2:0]         r_prev_lights;
    logic [6:0]         r_prev_tens;
    logic [6:0]         r_prev_ones;

    // Stage 2: state and outputs
    logic [1:0]         r_state;
    logic [6:0]         r_value;
    logic               r_value_valid;
    logic [c_err_w-1:0] r_err_flags;
    logic               r_err_pulse;
    logic [15:0]        r_phase_count;

    logic [3:0]         w_tens;
    logic [3:0]         w_ones;
    logic               w_tens_legal;
    logic               w_ones_legal;
    logic               w_legal;
    logic [6:0]         w_value;
    logic               w_event;
    logic [1:0]         w_obs_phase;
    logic               w_onehot;
    logic [6:0]         w_load;
    logic [1:0]         w_state_nxt;
    logic [c_err_w-1:0] w_err;
    logic               w_count_inc;

    seg7_decode u_dec_tens (
        .i_code  (r_seg_tens),
        .o_digit (w_tens),
        .o_legal (w_tens_legal)
    );

    seg7_decode u_dec_ones (
        .i_code  (r_seg_ones),
        .o_digit (w_ones),
        .o_legal (w_ones_legal)
    );

    assign w_legal = w_tens_legal & w_ones_legal;
    assign w_value = ({3'b000, w_tens} * 7'd10) + {3'b000, w_ones};
    assign w_event = {r_lights, r_seg_tens, r_seg_ones} !=
                     {r_prev_lights, r_prev_tens, r_prev_ones};

    // Light vector is {yellow, green, red}; anything not one-hot maps to none.
    always_comb begin
        w_obs_phase = c_ph_none;
        case (r_lights)
            3'b001:  w_obs_phase = c_ph_red;
            3'b010:  w_obs_phase = c_ph_green;
            3'b100:  w_obs_phase = c_ph_yellow;
            default: w_obs_phase = c_ph_none;
        endcase
    end

    assign w_onehot = (w_obs_phase != c_ph_none);

    always_comb begin
        w_load = 7'd0;
        case (w_obs_phase)
            c_ph_red:    w_load = RED_T;
            c_ph_green:  w_load = GREEN_T;
            c_ph_yellow: w_load = YELLOW_T;
            default:     w_load = 7'd0;
        endcase
    end

    // r_value always holds the last legally decoded value, so it is the
    // reference for both the step check and the early-change check.
    always_comb begin
        w_state_nxt = r_state;
        w_err       = '0;
        w_count_inc = 1'b0;
        if (w_event) begin
            if (r_state == c_st_sync) begin
                if (w_onehot && w_legal) begin
                    w_state_nxt = w_obs_phase;
                end
            end else if (!w_onehot) begin
                w_err[c_err_onehot] = 1'b1;
                w_err[c_err_seg]    = !w_legal;
                w_state_nxt         = c_st_sync;
            end else if (w_obs_phase == r_state) begin
                w_err[c_err_seg]  = !w_legal;
                w_err[c_err_step] = w_legal && ((w_value + 7'd1) != r_value);
            end else begin
                w_err[c_err_seg]   = !w_legal;
                w_err[c_err_early] = (r_value != 7'd0);
                w_err[c_err_order] = (w_obs_phase != next_phase(r_state));
                w_err[c_err_load]  = w_legal && (w_value != w_load);
                w_count_inc        = (r_state == c_st_yellow) &&
                                     (w_obs_phase == c_st_red) && (w_err == '0);
                w_state_nxt        = w_obs_phase;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            r_state <= c_st_sync;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            r_lights      <= 3'b000;
            r_seg_tens    <= 7'd0;
            r_seg_ones    <= 7'd0;
            r_clr         <= 1'b0;
            r_prev_lights <= 3'b000;
            r_prev_tens   <= 7'd0;
            r_prev_ones   <= 7'd0;
            r_value       <= 7'd0;
            r_value_valid <= 1'b0;
            r_err_flags   <= '0;
            r_err_pulse   <= 1'b0;
            r_phase_count <= 16'd0;
        end else begin
            r_lights      <= {yellow, green, red};
            r_seg_tens    <= seg_tens;
            r_seg_ones    <= seg_ones;
            r_clr         <= clr_err;
            r_prev_lights <= r_lights;
            r_prev_tens   <= r_seg_tens;
            r_prev_ones   <= r_seg_ones;
            if (w_legal) begin
                r_value <= w_value;
            end
            r_value_valid <= w_legal;
            r_err_flags   <= (r_clr ? '0 : r_err_flags) | w_err;
            r_err_pulse   <= |w_err;
            if (w_count_inc && (r_phase_count != 16'hFFFF)) begin
                r_phase_count <= r_phase_count + 16'd1;
            end
        end
    end

    assign value       = r_value;
    assign value_valid = r_value_valid;
    assign phase       = r_state;
    assign locked      = (r_state != c_st_sync);
    assign err_flags   = r_err_flags;
    assign err_pulse   = r_err_pulse;
    assign phase_count = r_phase_count;

endmodule

`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
//==============================================================================
// Module   : tb_traffic_light_monitor
// Purpose  : Scoreboard bench for traffic_light_monitor with a reference model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_traffic_light_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        red = 1'b0, green = 1'b0, yellow = 1'b0;
    logic [6:0]  seg_tens = 7'd0, seg_ones = 7'd0;
    logic        clr_err = 1'b0;
    logic [6:0]  value;
    logic        value_valid;
    logic [1:0]  phase;
    logic        locked;
    logic [5:0]  err_flags;
    logic        err_pulse;
    logic [15:0] phase_count;

    traffic_light_monitor dut (
        .clk_in      (clk),
        .rst         (rst),
        .red         (red),
        .green       (green),
        .yellow      (yellow),
        .seg_tens    (seg_tens),
        .seg_ones    (seg_ones),
        .clr_err     (clr_err),
        .value       (value),
        .value_valid (value_valid),
        .phase       (phase),
        .locked      (locked),
        .err_flags   (err_flags),
        .err_pulse   (err_pulse),
        .phase_count (phase_count)
    );

    always #5 clk = ~clk;

    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    typedef struct {
        logic [6:0]  value;
        logic        vv;
        logic [1:0]  phase;
        logic        locked;
        logic [5:0]  flags;
        logic        pulse;
        logic [15:0] cnt;
        int          due;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    bit [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    bit [6:0] bad_tab [3]  = '{7'h00, 7'h7E, 7'h01};
    bit [2:0] multi_tab [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
    int       load_tab [4] = '{0, 30, 25, 5};

    // Reference model: phase 0 none, 1 red, 2 green, 3 yellow
    int       m_phase = 0;
    int       m_last  = 0;
    bit       m_vv    = 0;
    bit [5:0] m_flags = 0;
    bit       m_pulse = 0;
    int       m_cnt   = 0;
    bit [2:0] m_prev_l = 0;
    bit [6:0] m_prev_t = 0, m_prev_o = 0;

    // Stimulus generator state
    int       gp = 1, gv = 0;
    bit [2:0] cur_l = 0;
    bit [6:0] cur_t = 0, cur_o = 0;

    function automatic int digit_of(input bit [6:0] code);
        for (int i = 0; i < 10; i++)
            if (seg_tab[i] == code) return i;
        return -1;
    endfunction

    task automatic model_step(input bit [2:0] l, input bit [6:0] t, input bit [6:0] o, input bit clr);
        int dt, dn, nv, lit, obs;
        bit legal, ev;
        bit [5:0] err;
        dt    = digit_of(t);
        dn    = digit_of(o);
        legal = (dt >= 0) && (dn >= 0);
        nv    = legal ? dt * 10 + dn : m_last;
        ev    = {l, t, o} != {m_prev_l, m_prev_t, m_prev_o};
        lit   = $countones(l);
        obs   = (lit != 1) ? 0 : (l[0] ? 1 : (l[1] ? 2 : 3));
        err   = '0;
        if (ev) begin
            if (m_phase == 0) begin
                if (lit == 1 && legal) m_phase = obs;
            end else if (lit != 1) begin
                err[0]  = 1'b1;
                err[1]  = !legal;
                m_phase = 0;
            end else begin
                err[1] = !legal;
                if (obs == m_phase) begin
                    if (legal && nv != m_last - 1) err[2] = 1'b1;
                end else begin
                    if (m_last != 0) err[5] = 1'b1;
                    if (obs != m_phase % 3 + 1) err[3] = 1'b1;
                    if (legal && nv != load_tab[obs]) err[4] = 1'b1;
                    if (m_phase == 3 && obs == 1 && err == 0 && m_cnt < 65535) m_cnt++;
                    m_phase = obs;
                end
            end
        end
        if (legal) m_last = nv;
        m_vv     = legal;
        m_flags  = (clr ? 6'd0 : m_flags) | err;
        m_pulse  = |err;
        m_prev_l = l;
        m_prev_t = t;
        m_prev_o = o;
    endtask

    task automatic apply(input bit rn, input bit [2:0] l, input bit [6:0] t, input bit [6:0] o, input bit clr);
        exp_t e;
        int   n;
        @(negedge clk);
        rst = rn; red = l[0]; green = l[1]; yellow = l[2];
        seg_tens = t; seg_ones = o; clr_err = clr;
        cur_l = l; cur_t = t; cur_o = o;
        n = edges;
        if (!rn) begin
            m_phase = 0; m_last = 0; m_vv = 0; m_flags = 0; m_pulse = 0; m_cnt = 0;
            m_prev_l = 0; m_prev_t = 0; m_prev_o = 0;
            // Reset acts one cycle sooner than data and overrides pending results.
            while (q.size() > 0 && q[$].due > n) void'(q.pop_back());
            e.due = n + 1;
        end else begin
            model_step(l, t, o, clr);
            e.due = n + 2;
        end
        e.value = 7'(m_last); e.vv = m_vv; e.phase = 2'(m_phase); e.locked = (m_phase != 0);
        e.flags = m_flags; e.pulse = m_pulse; e.cnt = 16'(m_cnt);
        q.push_back(e);
    endtask

    task automatic put(input int p, input int v, input bit clr);
        gp = p;
        gv = v;
        apply(1'b1, 3'b001 << (p - 1), seg_tab[v / 10], seg_tab[v % 10], clr);
    endtask

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", nm, edges, act, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0 && q[0].due == edges) begin
                e = q.pop_front();
                check("value",       16'(value),       16'(e.value));
                check("value_valid", 16'(value_valid), 16'(e.vv));
                check("phase",       16'(phase),       16'(e.phase));
                check("locked",      16'(locked),      16'(e.locked));
                check("err_flags",   16'(err_flags),   16'(e.flags));
                check("err_pulse",   16'(err_pulse),   16'(e.pulse));
                check("phase_count", phase_count,      e.cnt);
            end
        end
    end

    initial begin : stimulus
        int r, np, k;
        repeat (3) apply(1'b0, 3'b000, 7'h00, 7'h00, 1'b0);
        put(1, 0, 1'b0);
        for (int v = 25; v >= 0; v--) put(2, v, 1'b0);
        for (int v = 5;  v >= 0; v--) put(3, v, 1'b0);
        for (int v = 30; v >= 0; v--) put(1, v, 1'b0);
        put(3, 5, 1'b0);
        for (int v = 4;  v >= 0; v--) put(3, v, 1'b0);
        for (int v = 30; v >= 3; v--) put(1, v, 1'b0);
        put(2, 25, 1'b1);
        put(2, 23, 1'b0);
        put(2, 22, 1'b1);
        for (int v = 21; v >= 18; v--) put(2, v, 1'b0);
        apply(1'b1, cur_l, cur_t, 7'h00, 1'b0);
        put(2, 17, 1'b0);
        apply(1'b1, 3'b011, cur_t, cur_o, 1'b0);
        put(1, 10, 1'b0);
        put(1, 8, 1'b1);
        put(1, 7, 1'b0);
        apply(1'b0, cur_l, cur_t, cur_o, 1'b0);
        put(1, 6, 1'b0);

        for (int i = 0; i < 2500; i++) begin
            bit clr;
            r   = $urandom_range(0, 99);
            clr = ($urandom_range(0, 15) == 0);
            if (r < 25) begin
                apply(1'b1, cur_l, cur_t, cur_o, clr);
            end else if (r < 85) begin
                if (gv > 0) put(gp, gv - 1, clr);
                else begin np = gp % 3 + 1; put(np, load_tab[np], clr); end
            end else if (r < 88) begin
                put(gp, $urandom_range(0, 99), clr);
            end else if (r < 91) begin
                if ($urandom_range(0, 1) == 1)
                    apply(1'b1, cur_l, bad_tab[$urandom_range(0, 2)], cur_o, clr);
                else
                    apply(1'b1, cur_l, cur_t, bad_tab[$urandom_range(0, 2)], clr);
            end else if (r < 93) begin
                np = gp % 3 + 1; put(np, load_tab[np], clr);
            end else if (r < 95) begin
                np = (gp + 1) % 3 + 1; put(np, load_tab[np], clr);
            end else if (r < 97) begin
                np = gp % 3 + 1; put(np, $urandom_range(0, 99), clr);
            end else if (r < 99) begin
                apply(1'b1, multi_tab[$urandom_range(0, 4)], cur_t, cur_o, clr);
            end else begin
                repeat ($urandom_range(1, 2)) apply(1'b0, cur_l, cur_t, cur_o, 1'b0);
            end
        end

        repeat (3) apply(1'b1, cur_l, cur_t, cur_o, 1'b0);
        k = 0;
        while (q.size() > 0 && k < 10) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected results never compared, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

- Passive checker on the outputs of the traffic-light controller (`traffic_light`).
- Decodes the two 7-segment digits back to a binary countdown.
- Tracks the light phase sequence and checks each countdown step against the configured phase durations.
- Raises sticky error flags plus a one-cycle error pulse; used in benches and on-board self-test.

## Interface
- RED_T, 30, required first countdown value on entering red (1..99)
- GREEN_T, 25, required first countdown value on entering green (1..99)
- YELLOW_T, 5, required first countdown value on entering yellow (1..99)
- clk_in  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-low; sampled on clk_in rising edge
- red, green, yellow  input  1 each  light outputs under check
- seg_tens, seg_ones  input  7 each  digit segments {g,f,e,d,c,b,a}, active-high
- clr_err  input  1  clears err_flags
- value  output  7  decoded countdown, tens*10+ones (0..99)
- value_valid  output  1  both digits decoded to legal codes
- phase  output  2  00 none, 01 red, 10 green, 11 yellow
- locked  output  1  monitor synchronised to the sequence
- err_flags  output  6  sticky error bits (see Operation)
- err_pulse  output  1  high for one cycle per error event
- phase_count  output  16  completed red->green->yellow cycles, saturating at 16'hFFFF

## Operation
- **Segment codes, digits 0-9:** 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F. Any other code on either digit is illegal.
- **Event detection:** an event is any cycle in which the registered input vector differs from the previous registered vector. Checks run only on events.
- **Simultaneous updates:** the controller updates lights and digits in the same cycle. A skew between them is reported as an error, not tolerated.
- **FSM states:**
  - SYNC (reset state)
  - RED, GREEN, YELLOW
  - Legal order: RED->GREEN->YELLOW->RED.
- **SYNC:** stays in SYNC until a sample has exactly one light on and both digits legal. It then enters that light's state with locked=1. No load check is applied to this first phase.
- **Within a phase** (light unchanged, digits changed): new value must equal previous valid value - 1. Otherwise set bit2.
- **Phase change** to a one-hot light:
  - previous valid value must be 0; otherwise set bit5
  - new phase must be the successor of the current one; otherwise set bit3, but still adopt the observed phase
  - new value must equal that phase's _T parameter; otherwise set bit4
  - a transition YELLOW->RED with no error in that event increments phase_count
- **err_flags bits:**
  - bit0: lights not one-hot (zero or more than one lit)
  - bit1: illegal segment code
  - bit2: bad step within a phase
  - bit3: bad phase order
  - bit4: bad load value
  - bit5: early phase change (old value not 0)
- **Lights not one-hot (bit0):** FSM returns to SYNC, locked=0, phase=00.
- **Illegal segment code (bit1):** value_valid=0 and value holds the last valid value. The next legal value is step-checked against that last valid value.
- **Multiple errors in one event:** all corresponding bits set; a single err_pulse.
- **clr_err together with a new error:** the new error's bit is set; all other bits clear.
- **Reset:** synchronous reset overrides everything, including mid-phase. Next cycle the monitor is in SYNC with no stale comparison.
- **Arithmetic:** value = tens*10 + ones in 7 bits. The step check compares value+1 against the previous value so no underflow occurs. phase_count saturates at 16'hFFFF.

## Timing
- **Reset values:**
  - value=0, value_valid=0, phase=00, locked=0
  - err_flags=0, err_pulse=0, phase_count=0
- **Pipeline:** stage 1 registers the inputs; stage 2 decodes, compares and registers all outputs.
- **Latency:** 2 clk_in cycles from an input change to value, value_valid, phase, locked, err_flags and err_pulse.
- **clr_err:** takes effect on err_flags 1 cycle after being sampled high.
- **Back-to-back events:** events on consecutive cycles are each checked; throughput is one event per cycle.

## Structure
- **Package `traffic_pkg`:**
  - phase encoding (00/01/10/11)
  - segment code constants SEG_0..SEG_9
  - error bit index constants
  - `traffic_light` is retrofitted to use the same package.
- **Sub-module `seg7_decode`:** combinational, 7-bit code -> 4-bit digit + legal flag. Two instances, one per digit.
- **Top level:** FSM, comparison logic, flags and counter.

## Test plan
- Reset, then red with digits 3F/3F -> after 2 cycles: locked=1, phase=01, value=0, err_flags=0.
- Full legal cycle: red 30..0, green 25..0, yellow 5..0, red 30 -> phase_count=1, err_flags=0, err_pulse never high.
- Green 25->23 in one step -> err_flags=000100, err_pulse high for exactly one cycle, value=23.
- Red 0 -> yellow 5 -> bit3 set, phase=11. Separately, red 3 -> green 25 -> bit5 set.
- seg_ones=7F_h replaced by 00 mid-phase -> bit1, value_valid=0, value held. Next legal value (held-1) -> no bit2.
- Red+green both high -> bit0, locked=0, phase=00. clr_err asserted in the same cycle as a bad-step error -> only bit2 remains set. rst low mid-phase -> all outputs at reset values next cycle.
